uart_tx_frame_sequencer: RTL and testbench
==========================================

// Module: uart_tx_frame_sequencer
// PURPOSE
//  Controller that sequences one UART transmit frame at a time: fetches a word from the TX FIFO,
//  emits start bit, DATA_SIZE data bits LSB-first, optional parity bit, 1 or 2 stop bits.
//  Sits between uart_fifo (TX side) and the serial pin; bit timing derives from an external
//  baud_tick at OVERSAMPLE x baud rate. Provides busy/frame_done status for the status register.
// PARAMETERS
//  DATA_SIZE   8                      data bits per frame (5..9)
//  OVERSAMPLE  16                     baud_tick pulses per serial bit (>=2)
//  TICK_W      $clog2(OVERSAMPLE)     width of tick counter
//  BIT_W       $clog2(DATA_SIZE+1)    width of data-bit counter
// PORTS
//  clk         in   1          clock
//  reset_n     in   1          reset, asynchronous, active-low
//  baud_tick   in   1          1-clk pulse, OVERSAMPLE per bit period
//  tx_enable   in   1          1 = allowed to start new frames
//  parity_en   in   1          1 = insert parity bit
//  parity_odd  in   1          1 = odd parity, 0 = even
//  two_stop    in   1          1 = two stop bits, 0 = one
//  fifo_empty  in   1          TX FIFO empty flag
//  fifo_data   in   DATA_SIZE  TX FIFO read data, valid the clk after fifo_rd
//  fifo_rd     out  1          1-clk FIFO pop strobe
//  serial_out  out  1          TX line, idle high
//  busy        out  1          1 from fifo_rd cycle until frame end
//  frame_done  out  1          1-clk pulse when last stop bit completes
// BEHAVIOUR
//  Reset (async, any time incl. mid-frame): state=IDLE, serial_out=1, fifo_rd=0, busy=0,
//   frame_done=0, counters=0; frame in progress is abandoned, popped word is lost.
//  FSM: IDLE -> LOAD -> START -> DATA -> [PARITY] -> STOP -> IDLE. All outputs registered.
//  IDLE: serial_out=1. If tx_enable && !fifo_empty: fifo_rd=1 for this clk, go LOAD.
//  LOAD (1 clk): capture fifo_data into shift reg; latch parity_en/parity_odd/two_stop;
//   parity = ^data ^ parity_odd; clear tick_cnt, bit_cnt; go START. Config changes after
//   LOAD do not affect current frame.
//  Bit period: tick_cnt increments on each baud_tick; bit ends on baud_tick with
//   tick_cnt==OVERSAMPLE-1 (tick_cnt wraps to 0). Exactly OVERSAMPLE ticks per bit.
//  START: serial_out=0, one bit period -> DATA.
//  DATA: serial_out=shift[0]; at bit end shift right, bit_cnt++; after bit DATA_SIZE-1
//   go PARITY if latched parity_en else STOP.
//  PARITY: serial_out=parity, one bit period -> STOP.
//  STOP: serial_out=1; one bit period (two if latched two_stop, bit_cnt reused);
//   at last bit end: frame_done=1 one clk, go IDLE.
//  Back-to-back: next fifo_rd in the IDLE clk right after STOP; line stays high 2 clks
//   (IDLE+LOAD) beyond stop time plus alignment to next baud_tick period.
//  tx_enable deasserted mid-frame: current frame completes normally; no new fetch.
//  fifo_empty ignored outside IDLE; fifo_rd never asserted when fifo_empty=1.
//  baud_tick in IDLE/LOAD ignored (tick_cnt held 0).
//  busy=1 from fifo_rd clk through frame_done clk inclusive.
// TESTING (OVERSAMPLE=4, baud_tick every clk unless noted)
//  1 FIFO holds 0xA5, parity off, 1 stop -> one fifo_rd; line 0,1,0,1,0,0,1,0,1,1
//    each 4 clks; frame_done once; busy low after.
//  2 0xA5 parity_en even -> parity bit 0; parity_odd=1 -> parity bit 1; two_stop=1 ->
//    stop high 8 clks before frame_done.
//  3 FIFO holds 0x00,0xFF -> fifo_rd exactly twice; second start bit 2 clks after first
//    frame_done; 0xFF data bits all 1.
//  4 tx_enable=0 with FIFO non-empty -> no fifo_rd, serial_out=1; drop tx_enable mid-frame
//    -> frame finishes, no further fifo_rd.
//  5 baud_tick every 3rd clk -> each bit lasts 12 clks; toggle parity_odd/two_stop mid-frame
//    -> frame unchanged.
//  6 Assert reset_n=0 in DATA -> serial_out=1, busy=0 immediately; after release, next
//    FIFO word sent with correct framing.

Source files
------------

// File: rtl/uart_tx_frame_sequencer.sv
// Sequences one UART TX frame per FIFO word: start, LSB-first data, optional parity, 1/2 stop bits.
// Pop strobe is registered; the word is captured in LOAD, the clk after the pop, and the line is idle high between frames.
module uart_tx_frame_sequencer #(
  parameter int DATA_SIZE  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int TICK_W     = $clog2(OVERSAMPLE),
  parameter int BIT_W      = $clog2(DATA_SIZE + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 baud_tick,
  input  logic                 tx_enable,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  input  logic                 fifo_empty,
  input  logic [DATA_SIZE-1:0] fifo_data,
  output logic                 fifo_rd,
  output logic                 serial_out,
  output logic                 busy,
  output logic                 frame_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [TICK_W-1:0]    r_tick_cnt, w_tick_nxt;
  logic [BIT_W-1:0]     r_bit_cnt, w_bit_nxt;
  logic [DATA_SIZE-1:0] r_shift, w_shift_nxt;
  logic                 r_parity, w_parity_nxt;
  logic                 r_par_en, w_par_en_nxt;
  logic                 r_two_stop, w_two_stop_nxt;
  logic                 r_fifo_rd, r_serial, r_busy, r_done;
  logic                 w_bit_end, w_fetch, w_done, w_serial_nxt, w_busy_nxt;

  always_comb begin
    w_state_nxt    = r_state;
    w_tick_nxt     = r_tick_cnt;
    w_bit_nxt      = r_bit_cnt;
    w_shift_nxt    = r_shift;
    w_parity_nxt   = r_parity;
    w_par_en_nxt   = r_par_en;
    w_two_stop_nxt = r_two_stop;
    w_done         = 1'b0;
    w_bit_end      = baud_tick && (r_tick_cnt == TICK_W'(OVERSAMPLE - 1));

    // Bit timing runs only while a bit is on the line; IDLE/LOAD hold the counter at zero.
    if (baud_tick && (r_state != S_IDLE) && (r_state != S_LOAD)) begin
      w_tick_nxt = w_bit_end ? '0 : r_tick_cnt + TICK_W'(1);
    end

    case (r_state)
      S_IDLE: begin
        w_tick_nxt = '0;
        w_bit_nxt  = '0;
        if (r_fifo_rd) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_shift_nxt    = fifo_data;
        w_par_en_nxt   = parity_en;
        w_two_stop_nxt = two_stop;
        w_parity_nxt   = (^fifo_data) ^ parity_odd;
        w_tick_nxt     = '0;
        w_bit_nxt      = '0;
        w_state_nxt    = S_START;
      end
      S_START: begin
        if (w_bit_end) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = {1'b0, r_shift[DATA_SIZE-1:1]};
          if (r_bit_cnt == BIT_W'(DATA_SIZE - 1)) begin
            w_bit_nxt   = '0;
            w_state_nxt = r_par_en ? S_PARITY : S_STOP;
          end else begin
            w_bit_nxt = r_bit_cnt + BIT_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (r_two_stop && (r_bit_cnt == BIT_W'(0))) begin
            w_bit_nxt = BIT_W'(1);
          end else begin
            w_bit_nxt   = '0;
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Fetch is decided on the edge into an IDLE clk so the pop strobe itself is a flop.
    w_fetch = (w_state_nxt == S_IDLE) && tx_enable && !fifo_empty;

    case (w_state_nxt)
      S_START:  w_serial_nxt = 1'b0;
      S_DATA:   w_serial_nxt = w_shift_nxt[0];
      S_PARITY: w_serial_nxt = w_parity_nxt;
      default:  w_serial_nxt = 1'b1;
    endcase

    w_busy_nxt = w_fetch || w_done || (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_par_en   <= 1'b0;
      r_two_stop <= 1'b0;
      r_fifo_rd  <= 1'b0;
      r_serial   <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_tick_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_parity   <= w_parity_nxt;
      r_par_en   <= w_par_en_nxt;
      r_two_stop <= w_two_stop_nxt;
      r_fifo_rd  <= w_fetch;
      r_serial   <= w_serial_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done;
    end
  end

  assign fifo_rd    = r_fifo_rd;
  assign serial_out = r_serial;
  assign busy       = r_busy;
  assign frame_done = r_done;

endmodule

// File: tb/tb_uart_tx_frame_sequencer.sv
// Scoreboard bench: expected frames are queued with each FIFO word; a negedge monitor decodes the line.
module tb_uart_tx_frame_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       baud_tick = 1'b0;
  logic       tx_enable = 1'b0;
  logic       parity_en = 1'b0;
  logic       parity_odd = 1'b0;
  logic       two_stop = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rd, serial_out, busy, frame_done;

  always #5 clk = ~clk;

  uart_tx_frame_sequencer #(.DATA_SIZE(8), .OVERSAMPLE(4)) dut (
    .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .tx_enable(tx_enable),
    .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd(fifo_rd),
    .serial_out(serial_out), .busy(busy), .frame_done(frame_done)
  );

  typedef struct {
    int          nbits;
    logic [15:0] bits;
    int          cmin;
    int          cmax;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fifo_q[$];
  int checks = 0, errors = 0;
  int rd_count = 0, cyc = 0, tick_div = 1, bit_clks = 4;
  int last_gap = -1, last_done_cyc = -1000;
  bit rd_seen = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  // FIFO model with registered read data, plus the baud tick generator.
  initial begin : fifo_and_tick
    int tc;
    tc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rd_seen) begin
        rd_seen = 1'b0;
        if (fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
      end
      fifo_empty = (fifo_q.size() == 0);
      tc = (tc + 1) % tick_div;
      baud_tick = (tc == 0);
    end
  end

  initial begin : monitor
    logic samp [256];
    int n, nb, len, k, lim, i;
    bit cap, prev, busy_bad, lvl;
    logic [15:0] got;
    exp_t e;
    n = 0; cap = 0; prev = 1; busy_bad = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        cap  = 0;
        prev = 1;
      end else begin
        if (fifo_rd) begin
          rd_count++;
          rd_seen = 1'b1;
          chk("fifo_rd_nonempty", int'(fifo_q.size() > 0), 1);
        end
        if (cap) begin
          if (frame_done) begin
            got = '0; nb = 0; i = 0;
            lim = (n < 256) ? n : 256;
            while (i < lim) begin
              lvl = samp[i];
              len = 0;
              while (i < lim && samp[i] == lvl) begin
                len++;
                i++;
              end
              k = (len + bit_clks / 2) / bit_clks;
              for (int j = 0; j < k; j++) begin
                if (nb < 16) got[nb] = lvl;
                nb++;
              end
            end
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL frame_unexpected: got a %0d-bit frame, required none", nb);
            end else begin
              e = exp_q.pop_front();
              chk("frame_nbits", nb, e.nbits);
              chk("frame_bits", int'(got), int'(e.bits));
              checks++;
              if (n < e.cmin || n > e.cmax) begin
                errors++;
                $display("FAIL frame_clks: got %0d required %0d..%0d", n, e.cmin, e.cmax);
              end
              chk("busy_during_frame", int'(busy_bad), 0);
            end
            cap = 0;
            last_done_cyc = cyc;
          end else begin
            if (!busy) busy_bad = 1;
            if (n < 256) samp[n] = serial_out;
            n++;
          end
        end else if (prev && !serial_out) begin
          cap = 1;
          n = 1;
          samp[0] = 1'b0;
          busy_bad = !busy;
          last_gap = cyc - last_done_cyc;
        end else begin
          chk("idle_no_frame_done", int'(frame_done), 0);
        end
        prev = serial_out;
      end
    end
  end

  task automatic expect_frame(input int nb, input logic [15:0] bits, input int cmin, input int cmax);
    exp_t e;
    e.nbits = nb; e.bits = bits; e.cmin = cmin; e.cmax = cmax;
    exp_q.push_back(e);
  endtask

  task automatic fifo_put(input logic [7:0] w);
    @(negedge clk);
    fifo_q.push_back(w);
  endtask

  task automatic send(input logic [7:0] w, input int nb, input logic [15:0] bits, input int cmin, input int cmax);
    expect_frame(nb, bits, cmin, cmax);
    fifo_put(w);
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d frames pending, required 0", name, exp_q.size());
    end
  endtask

  task automatic wait_busy(input string name);
    int t;
    t = 0;
    while (!busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!busy) begin
      checks++;
      errors++;
      $display("FAIL %s_busy: got 0 required 1", name);
    end
  endtask

  initial begin : stimulus
    int rd0, bad;
    repeat (3) @(negedge clk);
    chk("rst_serial", int'(serial_out), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_fifo_rd", int'(fifo_rd), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    reset_n = 1'b1;
    tx_enable = 1'b1;

    // 0xA5, no parity, one stop
    send(8'hA5, 10, {6'b0, 1'b1, 8'hA5, 1'b0}, 40, 40);
    wait_done("t1");
    chk("t1_rd_count", rd_count, 1);
    @(negedge clk);
    chk("t1_busy_after", int'(busy), 0);

    // parity even / odd, then two stop bits
    parity_en = 1'b1; parity_odd = 1'b0;
    send(8'hA5, 11, {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 44, 44);
    wait_done("t2_even");
    parity_odd = 1'b1;
    send(8'hA5, 11, {5'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 44, 44);
    wait_done("t2_odd");
    parity_odd = 1'b0; two_stop = 1'b1;
    send(8'hA5, 12, {4'b0, 2'b11, 1'b0, 8'hA5, 1'b0}, 48, 48);
    wait_done("t2_two_stop");

    // back-to-back 0x00, 0xFF
    parity_en = 1'b0; two_stop = 1'b0;
    rd0 = rd_count;
    send(8'h00, 10, {6'b0, 1'b1, 8'h00, 1'b0}, 40, 40);
    send(8'hFF, 10, {6'b0, 1'b1, 8'hFF, 1'b0}, 40, 40);
    wait_done("t3");
    chk("t3_rd_count", rd_count - rd0, 2);
    chk("t3_gap", last_gap, 2);

    // tx_enable gating
    tx_enable = 1'b0;
    rd0 = rd_count;
    fifo_put(8'h5A);
    fifo_put(8'h33);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (serial_out !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("t4_rd_disabled", rd_count - rd0, 0);
    chk("t4_line_idle", bad, 0);
    expect_frame(10, {6'b0, 1'b1, 8'h5A, 1'b0}, 40, 40);
    tx_enable = 1'b1;
    wait_busy("t4");
    repeat (10) @(negedge clk);
    tx_enable = 1'b0;
    wait_done("t4");
    repeat (40) @(negedge clk);
    chk("t4_rd_after_drop", rd_count - rd0, 1);
    chk("t4_line_high", int'(serial_out), 1);

    // slow ticks, config changes mid-frame (0x33 still queued)
    tick_div = 3; bit_clks = 12;
    parity_en = 1'b1; parity_odd = 1'b0; two_stop = 1'b0;
    expect_frame(11, {5'b0, 1'b1, 1'b0, 8'h33, 1'b0}, 130, 132);
    tx_enable = 1'b1;
    wait_busy("t5");
    repeat (30) @(negedge clk);
    parity_odd = 1'b1; two_stop = 1'b1; parity_en = 1'b0;
    wait_done("t5");
    parity_odd = 1'b0; two_stop = 1'b0; parity_en = 1'b0;
    tick_div = 1; bit_clks = 4;
    repeat (3) @(negedge clk);

    // reset in the middle of DATA
    rd0 = rd_count;
    fifo_put(8'h3C);
    wait_busy("t6");
    repeat (10) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_serial", int'(serial_out), 1);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_fifo_rd", int'(fifo_rd), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    send(8'h96, 10, {6'b0, 1'b1, 8'h96, 1'b0}, 40, 40);
    wait_done("t6");
    chk("t6_rd_count", rd_count - rd0, 2);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
